// File: rtl/mt9v034_axis_packer.sv
// Converts deserialized MT9V034 camera words into an 8-bit AXI4-Stream video stream.
// tuser = start of frame, tlast = end of line; full FIFO or lock loss drops the rest of the frame.
module mt9v034_axis_packer #(
   parameter int FIFO_AW = 4,
   parameter int CNT_W   = 16
) (
   input  logic             pxclk,
   input  logic             resetn,
   input  logic             pixel_data_valid,
   input  logic             frame_valid,
   input  logic             line_valid,
   input  logic [7:0]       pixel_data,
   input  logic             receiver_locked,
   output logic [7:0]       m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tuser,
   output logic             m_axis_tlast,
   input  logic             overflow_clr,
   output logic             overflow_sticky,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] line_pixels,
   output logic [CNT_W-1:0] frame_lines
);

   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_FRAME, S_DROP} state_t;

   typedef struct packed {
      logic       user;
      logic       last;
      logic [7:0] data;
   } beat_t;

   state_t state, state_nxt, eff_state;

   logic             hold_vld, hold_vld_nxt;
   logic [7:0]       hold_data, hold_data_nxt;
   logic             hold_user, hold_user_nxt;
   logic             push_vld, push_nxt;
   beat_t            push_beat, push_beat_nxt;
   logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
   logic [CNT_W-1:0] line_cnt, line_cnt_nxt;
   logic [CNT_W-1:0] fc_nxt, lp_nxt, fl_nxt;
   logic             sticky_nxt;
   logic             is_pix;

   beat_t            mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr, rp_n;
   logic             full, wr_en, ovf, hs;

   assign is_pix = frame_valid & line_valid;
   assign full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign wr_en  = push_vld & ~full;
   assign ovf    = push_vld & full;

   always_comb begin
      state_nxt     = state;
      hold_vld_nxt  = hold_vld;
      hold_data_nxt = hold_data;
      hold_user_nxt = hold_user;
      push_nxt      = 1'b0;
      push_beat_nxt = push_beat;
      pix_cnt_nxt   = pix_cnt;
      line_cnt_nxt  = line_cnt;
      fc_nxt        = frame_count;
      lp_nxt        = line_pixels;
      fl_nxt        = frame_lines;
      // A rejected push lands a cycle late, so the sample in this cycle is judged as DROP.
      eff_state     = ovf ? S_DROP : state;
      if (ovf) begin
         hold_vld_nxt = 1'b0;
         state_nxt    = S_DROP;
      end
      if (!receiver_locked) begin
         state_nxt    = S_SYNC;
         hold_vld_nxt = 1'b0;
      end else if (pixel_data_valid) begin
         case (eff_state)
            S_SYNC, S_DROP: if (!frame_valid) state_nxt = S_IDLE;
            S_IDLE: if (is_pix) begin
               state_nxt     = S_FRAME;
               hold_vld_nxt  = 1'b1;
               hold_data_nxt = pixel_data;
               hold_user_nxt = 1'b1;
               pix_cnt_nxt   = CNT_W'(1);
               line_cnt_nxt  = '0;
            end
            S_FRAME: begin
               if (is_pix) begin
                  if (hold_vld) begin
                     push_nxt      = 1'b1;
                     push_beat_nxt = '{user: hold_user, last: 1'b0, data: hold_data};
                  end
                  hold_vld_nxt  = 1'b1;
                  hold_data_nxt = pixel_data;
                  hold_user_nxt = 1'b0;
                  if (pix_cnt != '1) pix_cnt_nxt = pix_cnt + CNT_W'(1);
               end else begin
                  // Line update first so a joint LV/FV fall counts the closing line.
                  if (hold_vld) begin
                     push_nxt      = 1'b1;
                     push_beat_nxt = '{user: hold_user, last: 1'b1, data: hold_data};
                     hold_vld_nxt  = 1'b0;
                     lp_nxt        = pix_cnt;
                     pix_cnt_nxt   = '0;
                     line_cnt_nxt  = line_cnt + CNT_W'(1);
                  end
                  if (!frame_valid) begin
                     fl_nxt       = line_cnt + CNT_W'(hold_vld);
                     line_cnt_nxt = '0;
                     fc_nxt       = frame_count + CNT_W'(1);
                     state_nxt    = S_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
      if (ovf || (!receiver_locked && state == S_FRAME)) sticky_nxt = 1'b1;
      else if (overflow_clr)                             sticky_nxt = 1'b0;
      else                                               sticky_nxt = overflow_sticky;
   end

   always_ff @(posedge pxclk or negedge resetn) begin
      if (!resetn) begin
         state           <= S_SYNC;
         hold_vld        <= 1'b0;
         hold_data       <= '0;
         hold_user       <= 1'b0;
         push_vld        <= 1'b0;
         push_beat       <= '0;
         pix_cnt         <= '0;
         line_cnt        <= '0;
         frame_count     <= '0;
         line_pixels     <= '0;
         frame_lines     <= '0;
         overflow_sticky <= 1'b0;
      end else begin
         state           <= state_nxt;
         hold_vld        <= hold_vld_nxt;
         hold_data       <= hold_data_nxt;
         hold_user       <= hold_user_nxt;
         push_vld        <= push_nxt;
         push_beat       <= push_beat_nxt;
         pix_cnt         <= pix_cnt_nxt;
         line_cnt        <= line_cnt_nxt;
         frame_count     <= fc_nxt;
         line_pixels     <= lp_nxt;
         frame_lines     <= fl_nxt;
         overflow_sticky <= sticky_nxt;
      end
   end

   always_ff @(posedge pxclk) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= push_beat;
   end

   // The output register mirrors the FIFO head; the entry is retired only on handshake,
   // so the output stage counts against the FIFO depth.
   assign hs   = m_axis_tvalid & m_axis_tready;
   assign rp_n = hs ? rd_ptr + (FIFO_AW+1)'(1) : rd_ptr;

   always_ff @(posedge pxclk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
         rd_ptr <= rp_n;
         if (!m_axis_tvalid || hs) begin
            m_axis_tvalid <= (rp_n != wr_ptr);
            if (rp_n != wr_ptr) begin
               m_axis_tdata <= mem[rp_n[FIFO_AW-1:0]].data;
               m_axis_tuser <= mem[rp_n[FIFO_AW-1:0]].user;
               m_axis_tlast <= mem[rp_n[FIFO_AW-1:0]].last;
            end
         end
      end
   end

endmodule

// File: tb/tb_mt9v034_axis_packer.sv
// Scoreboard bench: frame stimulus queues the expected beats, a monitor checks every handshake.
module tb_mt9v034_axis_packer;

   localparam int AW = 4;
   localparam int CW = 16;

   logic          pxclk = 1'b0;
   logic          resetn = 1'b0;
   logic          pdv = 1'b0, fv = 1'b0, lv = 1'b0, locked = 1'b1;
   logic [7:0]    pd = 8'h00;
   logic          tready_fix = 1'b1, rnd_en = 1'b0, rnd_bit = 1'b0, clr = 1'b0;
   logic          tready;
   logic [7:0]    tdata;
   logic          tvalid, tuser, tlast, sticky;
   logic [CW-1:0] fcount, lpix, flines;

   int            errors = 0;
   int            checks = 0;
   logic [9:0]    expq [$];

   assign tready = rnd_en ? rnd_bit : tready_fix;

   mt9v034_axis_packer #(.FIFO_AW(AW), .CNT_W(CW)) dut (
      .pxclk(pxclk), .resetn(resetn), .pixel_data_valid(pdv), .frame_valid(fv),
      .line_valid(lv), .pixel_data(pd), .receiver_locked(locked),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tuser(tuser), .m_axis_tlast(tlast), .overflow_clr(clr),
      .overflow_sticky(sticky), .frame_count(fcount), .line_pixels(lpix),
      .frame_lines(flines)
   );

   always #5 pxclk = ~pxclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge pxclk);
      #1;
   endtask

   task automatic word(input logic f, input logic l, input logic [7:0] d, input int gap);
      pdv = 1'b1; fv = f; lv = l; pd = d;
      tick();
      pdv = 1'b0;
      repeat (gap) tick();
   endtask

   // Blanking, nl lines of np pixels with LV-low blanking between lines, then FV low.
   task automatic frame(input int nl, input int np, input int gap, input logic [7:0] seed,
                        input int max_exp, input bit together);
      int idx = 0;
      logic [7:0] d;
      word(1'b0, 1'b0, 8'h00, gap);
      word(1'b0, 1'b0, 8'h00, gap);
      for (int l = 0; l < nl; l++) begin
         for (int p = 0; p < np; p++) begin
            d = seed + 8'(l * np + p);
            word(1'b1, 1'b1, d, gap);
            if (idx < max_exp) expq.push_back({idx == 0, p == np - 1, d});
            idx++;
         end
         if (!(together && l == nl - 1)) begin
            word(1'b1, 1'b0, 8'h00, gap);
            word(1'b1, 1'b0, 8'h00, gap);
         end
      end
      word(1'b0, 1'b0, 8'h00, gap);
      word(1'b0, 1'b0, 8'h00, gap);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (expq.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      chk(name, 32'(expq.size()), 32'd0);
      repeat (10) tick();
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge pxclk);
         #1;
         rnd_bit = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compare every accepted beat against the queue; check payload holds while stalled.
   initial begin
      logic [9:0] got, want, prev;
      logic       stall;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge pxclk);
         if (!resetn) begin
            stall = 1'b0;
         end else begin
            got = {tuser, tlast, tdata};
            if (stall) begin
               checks++;
               if (!tvalid || got !== prev) begin
                  errors++;
                  $display("FAIL stall_hold: got valid=%0b beat=%h expected valid=1 beat=%h",
                           tvalid, got, prev);
               end
            end
            if (tvalid && tready) begin
               checks++;
               if (expq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got %h expected none", got);
               end else begin
                  want = expq.pop_front();
                  if (got !== want) begin
                     errors++;
                     $display("FAIL beat: got user/last/data=%h expected %h", got, want);
                  end
               end
            end
            stall = tvalid && !tready;
            prev  = got;
         end
      end
   end

   initial begin
      // Reset state
      tick(); tick();
      resetn = 1'b1;
      chk("rst_tvalid", 32'(tvalid), 32'd0);
      chk("rst_beat", 32'({tuser, tlast, tdata}), 32'd0);
      chk("rst_sticky", 32'(sticky), 32'd0);
      chk("rst_counts", 32'({fcount, lpix}), 32'd0);
      chk("rst_flines", 32'(flines), 32'd0);

      // Basic 3x4 frame
      frame(3, 4, 0, 8'h10, 1000, 1'b0);
      drain("t1_drain");
      chk("t1_line_pixels", 32'(lpix), 32'd4);
      chk("t1_frame_lines", 32'(flines), 32'd3);
      chk("t1_frame_count", 32'(fcount), 32'd1);
      chk("t1_sticky", 32'(sticky), 32'd0);

      // Reset released while FV is high: the partial frame must be ignored
      resetn = 1'b0;
      pdv = 1'b1; fv = 1'b1; lv = 1'b1; pd = 8'hEE;
      tick(); tick();
      resetn = 1'b1;
      chk("t2_rst_count", 32'(fcount), 32'd0);
      word(1'b1, 1'b1, 8'hE1, 0); word(1'b1, 1'b1, 8'hE2, 0);
      word(1'b1, 1'b0, 8'h00, 0); word(1'b1, 1'b1, 8'hE3, 0);
      word(1'b1, 1'b1, 8'hE4, 0); word(1'b1, 1'b0, 8'h00, 0);
      frame(2, 3, 0, 8'h40, 1000, 1'b0);
      drain("t2_drain");
      chk("t2_frame_count", 32'(fcount), 32'd1);
      chk("t2_line_pixels", 32'(lpix), 32'd3);
      chk("t2_frame_lines", 32'(flines), 32'd2);

      // Backpressure overflow: 17th push drops
      tready_fix = 1'b0;
      frame(4, 8, 0, 8'h20, 16, 1'b0);
      chk("t3_sticky", 32'(sticky), 32'd1);
      chk("t3_frame_count", 32'(fcount), 32'd1);
      tready_fix = 1'b1;
      drain("t3_drain");
      pulse_clr();
      chk("t3_clr", 32'(sticky), 32'd0);
      frame(2, 4, 0, 8'h90, 1000, 1'b0);
      drain("t3_next_drain");
      chk("t3_next_count", 32'(fcount), 32'd2);
      chk("t3_next_lines", 32'(flines), 32'd2);

      // Lock loss mid-line
      word(1'b0, 1'b0, 8'h00, 0); word(1'b0, 1'b0, 8'h00, 0);
      expq.push_back({1'b1, 1'b0, 8'h50});
      expq.push_back({1'b0, 1'b0, 8'h51});
      word(1'b1, 1'b1, 8'h50, 0); word(1'b1, 1'b1, 8'h51, 0); word(1'b1, 1'b1, 8'h52, 0);
      locked = 1'b0;
      tick();
      locked = 1'b1;
      word(1'b1, 1'b1, 8'h53, 0); word(1'b1, 1'b1, 8'h54, 0); word(1'b1, 1'b0, 8'h00, 0);
      word(1'b1, 1'b1, 8'h60, 0); word(1'b1, 1'b1, 8'h61, 0); word(1'b1, 1'b0, 8'h00, 0);
      drain("t4_drain");
      chk("t4_sticky", 32'(sticky), 32'd1);
      chk("t4_frame_count", 32'(fcount), 32'd2);
      pulse_clr();
      chk("t4_clr", 32'(sticky), 32'd0);
      frame(2, 4, 0, 8'h70, 1000, 1'b0);
      drain("t4_next_drain");
      chk("t4_next_count", 32'(fcount), 32'd3);

      // Random backpressure, sparse samples, 5 frames of 16x10
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      rnd_en = 1'b1;
      for (int f = 0; f < 5; f++) frame(10, 16, 2, 8'(f * 37), 1000, 1'b0);
      drain("t5_drain");
      rnd_en = 1'b0;
      chk("t5_frame_count", 32'(fcount), 32'd5);
      chk("t5_line_pixels", 32'(lpix), 32'd16);
      chk("t5_frame_lines", 32'(flines), 32'd10);

      // LV and FV fall on the same sample
      frame(3, 5, 0, 8'hA0, 1000, 1'b1);
      drain("t6_drain");
      chk("t6_frame_lines", 32'(flines), 32'd3);
      chk("t6_line_pixels", 32'(lpix), 32'd5);
      chk("t6_frame_count", 32'(fcount), 32'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mt9v034_axis_packer.md
Name: mt9v034_axis_packer

Overview:
- Downstream of the MT9V034 LVDS deserializer, in the pxclk domain.
- Takes the deserializer's per-word outputs (pixel_data_valid, frame_valid, line_valid, pixel_data[7:0], receiver_locked) and converts them into an 8-bit AXI4-Stream video stream.
- tuser marks start-of-frame and tlast marks end-of-line.
- A small FIFO absorbs downstream backpressure. Overflow or loss of lock drops the rest of the frame, and the packer resynchronises on the next frame.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW beats of {tuser,tlast,data[7:0]}
CNT_W, 16, width of the pixel/line/frame status counters

Ports:
pxclk  in  1  pixel clock; sole clock of the block
resetn  in  1  asynchronous active-low reset
pixel_data_valid  in  1  one deserialized camera word is present this cycle
frame_valid  in  1  FV bit of the current word
line_valid  in  1  LV bit of the current word
pixel_data  in  8  pixel value of the current word
receiver_locked  in  1  deserializer data lock
m_axis_tdata  out  8  pixel
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tuser  out  1  first pixel of frame
m_axis_tlast  out  1  last pixel of line
overflow_clr  in  1  clears overflow_sticky
overflow_sticky  out  1  a frame was truncated by a full FIFO or lock loss
frame_count  out  CNT_W  frames completed without drop; wraps
line_pixels  out  CNT_W  pixel count of the most recently completed line
frame_lines  out  CNT_W  line count of the most recently completed frame

Behaviour:
- Reset: all outputs 0, FIFO empty, hold register invalid, state SYNC.
- Word acceptance:
  - A word is a "sample" only when pixel_data_valid=1.
  - Cycles with pixel_data_valid=0 change nothing except the AXI side.
  - A sample with FV=1 and LV=1 is a pixel.
- States (all transitions on samples or lock):
  - SYNC: wait for a sample with FV=0, then go to IDLE.
  - IDLE: on the first pixel, go to FRAME with sof_pending=1.
  - FRAME: capture pixels.
  - DROP: discard samples until a sample with FV=0, then go to IDLE.
  - receiver_locked=0 in any state: go to SYNC and invalidate the hold register. If the state was FRAME, set overflow_sticky.
- Hold register (one pixel deep), used because end-of-line is only known after the last pixel:
  - Pixel arrives, hold valid: push the held beat with tlast=0, then load the new pixel.
  - Pixel arrives, hold invalid: load the new pixel.
  - Loaded pixel gets tuser=sof_pending; sof_pending then clears.
  - Sample with LV=0 or FV=0 while hold valid: push the held beat with tlast=1 and invalidate hold.
- Push timing:
  - A push is written in the cycle after the triggering sample.
  - At most one push per sample.
- Overflow:
  - A push while the FIFO is full drops the beat, sets overflow_sticky, invalidates hold, and goes to DROP.
  - No synthetic tlast is emitted; downstream resyncs on tuser.
  - frame_count is not incremented for a dropped frame.
- Counters:
  - Pixel counter increments per pixel and saturates at all-ones.
  - On an LV falling sample: line_pixels <= pixel counter, pixel counter cleared, line counter incremented.
  - On an FV falling sample in FRAME: frame_lines <= line counter, line counter cleared, frame_count += 1 (wraps), state goes to IDLE.
  - If LV and FV fall on the same sample, do the line update first, so frame_lines includes that line.
- overflow_clr:
  - Clears overflow_sticky.
  - Clear and a new set in the same cycle: set wins.
- AXI output:
  - One registered output stage fed by a first-word-fall-through FIFO.
  - Latency from push to m_axis_tvalid is 2 cycles when FIFO and output are empty.
  - tdata/tuser/tlast are held stable while tvalid=1 and tready=0; tvalid never deasserts without a handshake.
  - Full throughput: 1 beat per cycle when tready=1.
  - FIFO full/empty are derived from FIFO_AW+1-bit pointers; wrap-around is exercised by the bench.

Test Plan:
- 3-line, 4-pixel frame (FV/LV framed, blanking samples between lines), tready=1 -> 12 beats. tuser=1 only on beat 0; tlast=1 on beats 3, 7, 11. Afterwards line_pixels=4, frame_lines=3, frame_count=1.
- Reset out of reset mid-frame (FV=1 at first sample) -> no output until FV goes low and the next frame starts. The next frame's first beat has tuser=1.
- tready=0 for a full 4-line × 8-pixel frame with FIFO_AW=4 -> the 17th push drops. Required result:
  - 16 beats queued, overflow_sticky=1.
  - Rest of frame discarded, frame_count unchanged.
  - The next frame is delivered intact once tready=1.
- receiver_locked deasserted for 1 cycle mid-line -> overflow_sticky=1, state SYNC, no further beats until a full new frame. overflow_clr then returns overflow_sticky to 0.
- Random tready (50%) over 5 frames of 16×10 pixels, pixel_data_valid every 3rd cycle -> output matches the reference stream beat-for-beat (data/tuser/tlast). Payload held stable while stalled; frame_count=5.
- LV and FV fall on the same sample -> last beat has tlast=1 and frame_lines counts that line.
